// File: rtl/camera_param_shadow.sv
// Camera/shading parameter shadow: waits for HPS PIO words to settle, then commits them atomically at a frame start.
// Optional macro CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN adds a 16-bit wrapping commit_count output.
module camera_param_shadow #(
  parameter int NUM_WORDS     = 17,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WORDS*32-1:0]   param_in,
  input  logic                      frame_start,
  input  logic                      freeze,
  output logic [NUM_WORDS*32-1:0]   active_params,
  output logic                      params_updated,
  output logic                      pending,
  output logic                      settling
`ifdef CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN
  ,
  output logic [15:0]               commit_count
`endif
);

  localparam int W = NUM_WORDS * 32;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLING = 2'd1;
  localparam logic [1:0] ST_PENDING  = 2'd2;

  logic [W-1:0] s_q, s_d;
  logic [W-1:0] active_q, active_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   state_q, state_d;
  logic         updated_q, updated_d;
  logic         pending_q, pending_d;
  logic         settling_q, settling_d;
  logic         diff;
  logic         commit;

  always_comb begin
    s_d        = param_in;
    active_d   = active_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    updated_d  = 1'b0;
    commit     = 1'b0;
    diff       = (param_in != s_q);

    case (state_q)
      ST_IDLE: begin
        if (diff) begin
          state_d = ST_SETTLING;
          cnt_d   = 8'd0;
        end
      end
      ST_SETTLING: begin
        if (diff) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          // A set that merely reverts to the live values has nothing to commit.
          state_d = (s_q != active_q) ? ST_PENDING : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PENDING: begin
        // A fresh write wins over a coincident frame_start so a half-updated set is never taken.
        if (diff) begin
          state_d = ST_SETTLING;
          cnt_d   = 8'd0;
        end else if (frame_start && !freeze) begin
          commit    = 1'b1;
          active_d  = s_q;
          updated_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    pending_d  = (state_d == ST_PENDING);
    settling_d = (state_d == ST_SETTLING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= '0;
      active_q   <= '0;
      cnt_q      <= 8'd0;
      state_q    <= ST_IDLE;
      updated_q  <= 1'b0;
      pending_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      updated_q  <= updated_d;
      pending_q  <= pending_d;
      settling_q <= settling_d;
    end
  end

  assign active_params  = active_q;
  assign params_updated = updated_q;
  assign pending        = pending_q;
  assign settling       = settling_q;

`ifdef CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN
  logic [15:0] commit_count_q, commit_count_d;

  always_comb begin
    commit_count_d = commit_count_q;
    if (commit) begin
      commit_count_d = commit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_count_q <= 16'd0;
    end else begin
      commit_count_q <= commit_count_d;
    end
  end

  assign commit_count = commit_count_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_camera_param_shadow.sv
// Scoreboard bench for camera_param_shadow: run-length reference model feeds expectation queues checked by a monitor.
module tb_camera_param_shadow;
  localparam int NW  = 17;
  localparam int SC  = 4;
  localparam int W   = NW * 32;
  localparam int BIG = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] param_in;
  logic         frame_start;
  logic         freeze;
  logic [W-1:0] active_params;
  logic         params_updated;
  logic         pending;
  logic         settling;
`ifdef CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN
  logic [15:0]  commit_count;
`endif

  camera_param_shadow #(.NUM_WORDS(NW), .STABLE_CYCLES(SC)) dut (
    .clk            (clk),
    .reset          (reset),
    .param_in       (param_in),
    .frame_start    (frame_start),
    .freeze         (freeze),
    .active_params  (active_params),
    .params_updated (params_updated),
    .pending        (pending),
    .settling       (settling)
`ifdef CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN
    ,
    .commit_count   (commit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] act;
    logic         upd;
    logic         pen;
    logic         set;
    logic [15:0]  cnt;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] commit_q[$];
  int           errors = 0;
  int           checks = 0;

  // Reference model: time since the input last moved decides everything.
  logic [W-1:0] m_prev;
  logic [W-1:0] m_active;
  int           m_run;
  logic         m_pend;
  logic [15:0]  m_count;
  int           m_commits;

  logic [W-1:0] p_cur;

  task automatic step(input logic [W-1:0] p, input logic fs, input logic fr, input logic rst);
    exp_t   e;
    logic   changed;
    logic   upd;
    @(negedge clk);
    param_in    = p;
    frame_start = fs;
    freeze      = fr;
    reset       = rst;
    upd = 1'b0;
    if (rst) begin
      m_prev   = '0;
      m_active = '0;
      m_run    = BIG;
      m_pend   = 1'b0;
      m_count  = 16'd0;
    end else begin
      changed = (p != m_prev);
      if (m_pend && !changed && fs && !fr) begin
        upd       = 1'b1;
        m_active  = p;
        m_pend    = 1'b0;
        m_count   = m_count + 16'd1;
        m_commits++;
        commit_q.push_back(p);
      end
      if (changed) begin
        m_run  = 0;
        m_pend = 1'b0;
      end else begin
        if (m_run < BIG) m_run++;
        if (m_run == SC) m_pend = (p != m_active);
      end
      m_prev = p;
    end
    e.act = m_active;
    e.upd = upd;
    e.pen = m_pend;
    e.set = (m_run < SC);
    e.cnt = m_count;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic fr, input int fs_period);
    for (int i = 0; i < n; i++) begin
      step(p_cur, (fs_period > 0) && (i % fs_period == fs_period - 1), fr, 1'b0);
    end
  endtask

  // Monitor: compares every cycle's outputs and checks each update pulse against the commit queue.
  initial begin
    exp_t e;
    logic [W-1:0] c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (active_params !== e.act) begin
          errors++;
          $display("FAIL active_params got=%h exp=%h t=%0t", active_params, e.act, $time);
        end
        checks++;
        if (params_updated !== e.upd) begin
          errors++;
          $display("FAIL params_updated got=%b exp=%b t=%0t", params_updated, e.upd, $time);
        end
        checks++;
        if (pending !== e.pen) begin
          errors++;
          $display("FAIL pending got=%b exp=%b t=%0t", pending, e.pen, $time);
        end
        checks++;
        if (settling !== e.set) begin
          errors++;
          $display("FAIL settling got=%b exp=%b t=%0t", settling, e.set, $time);
        end
`ifdef CAMERA_PARAM_SHADOW_COMMIT_COUNT_EN
        checks++;
        if (commit_count !== e.cnt) begin
          errors++;
          $display("FAIL commit_count got=%0d exp=%0d t=%0t", commit_count, e.cnt, $time);
        end
`endif
      end
      if (params_updated === 1'b1) begin
        checks++;
        if (commit_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit active=%h t=%0t", active_params, $time);
        end else begin
          c = commit_q.pop_front();
          if (active_params !== c) begin
            errors++;
            $display("FAIL commit_data got=%h exp=%h t=%0t", active_params, c, $time);
          end
        end
      end
    end
  end

  initial begin
    int w;
    reset       = 1'b1;
    param_in    = '0;
    frame_start = 1'b0;
    freeze      = 1'b0;
    p_cur       = '0;
    m_prev      = '0;
    m_active    = '0;
    m_run       = BIG;
    m_pend      = 1'b0;
    m_count     = 16'd0;
    m_commits   = 0;

    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b1);
    hold(10, 1'b0, 0);

    // Single word update, periodic frame starts.
    p_cur[31:0] = 32'h0001_0000;
    hold(40, 1'b0, 20);

    // Lookat matrix written one word per cycle.
    for (int i = 3; i < 12; i++) begin
      p_cur[i*32 +: 32] = $urandom;
      step(p_cur, 1'b0, 1'b0, 1'b0);
    end
    hold(30, 1'b0, 10);

    // Change coincident with frame_start while pending.
    p_cur[12*32 +: 32] = 32'h0000_0007;
    hold(6, 1'b0, 0);
    p_cur[12*32 +: 32] = 32'h0000_0009;
    step(p_cur, 1'b1, 1'b0, 1'b0);
    hold(8, 1'b0, 0);
    step(p_cur, 1'b1, 1'b0, 1'b0);
    hold(3, 1'b0, 0);

    // Freeze across two frame starts, then release.
    p_cur[16*32 +: 32] = 32'h0000_0003;
    hold(6, 1'b0, 0);
    hold(12, 1'b1, 5);
    hold(7, 1'b0, 7);

    // Change then restore: settles back to the live set, no commit.
    begin
      logic [W-1:0] saved;
      saved = p_cur;
      p_cur[0 +: 32] = 32'hDEAD_BEEF;
      step(p_cur, 1'b0, 1'b0, 1'b0);
      step(p_cur, 1'b0, 1'b0, 1'b0);
      p_cur = saved;
      hold(10, 1'b0, 3);
    end

    // Reset while pending discards the staged set.
    p_cur[13*32 +: 32] = 32'h1234_5678;
    hold(6, 1'b0, 0);
    step(p_cur, 1'b0, 1'b0, 1'b1);
    hold(10, 1'b0, 0);
    hold(6, 1'b0, 6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        w = $urandom_range(0, NW - 1);
        p_cur[w*32 +: 32] = $urandom;
      end
      step(p_cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 499) == 0));
    end
    hold(8, 1'b0, 4);

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || commit_q.size() != 0) begin
      errors++;
      $display("FAIL drain exp_left=%0d commits_left=%0d exp=0", exp_q.size(), commit_q.size());
    end
    checks++;
    if (m_commits < 4) begin
      errors++;
      $display("FAIL commit_coverage got=%0d exp>=4", m_commits);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
